// File: rtl/sata_oob_pkg.sv
// sata_oob_pkg: shared types and defaults for the SATA OOB link controller.
// Holds the FSM state encoding, the default timeout/sync constants and the
// state-to-output decode used by sata_oob_ctrl.
package sata_oob_pkg;

  // State encoding; the numeric values are also the exported state_code.
  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_COMRESET     = 4'd1,
    ST_WAIT_COMINIT = 4'd2,
    ST_COMWAKE      = 4'd3,
    ST_WAIT_COMWAKE = 4'd4,
    ST_WAIT_OOBFIN  = 4'd5,
    ST_SEND_D102    = 4'd6,
    ST_SEND_ALIGN   = 4'd7,
    ST_LINKUP       = 4'd8
  } oob_state_t;

  // Default timing, in clk cycles at 150 MHz.
  localparam int unsigned DEF_ALIGN_TIMEOUT = 32'd132000;   // 880 us
  localparam int unsigned DEF_RETRY_TIMEOUT = 32'd1500000;  // 10 ms
  localparam int unsigned DEF_SYNC_COUNT    = 32'd3;

  // Transmit-side and status outputs, one bit per state at most.
  typedef struct packed {
    logic comreset;
    logic comwake;
    logic d102;
    logic align;
    logic linkup;
  } oob_tx_t;

  // Map a state to its output pattern; at most one bit is ever set.
  function automatic oob_tx_t decode_outputs(input oob_state_t st);
    oob_tx_t o;
    o = '{comreset: 1'b0, comwake: 1'b0, d102: 1'b0, align: 1'b0, linkup: 1'b0};
    case (st)
      ST_COMRESET:   o.comreset = 1'b1;
      ST_COMWAKE:    o.comwake  = 1'b1;
      ST_SEND_D102:  o.d102     = 1'b1;
      ST_SEND_ALIGN: o.align    = 1'b1;
      ST_LINKUP:     o.linkup   = 1'b1;
      default:       o.linkup   = 1'b0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sata_oob_timer.sv
// sata_oob_timer: loadable saturating timeout counter.
// The count restarts at zero on clear and then advances once per cycle until
// it reaches limit-1, where it holds. expired is high while count == limit-1.
module sata_oob_timer #(
  parameter int unsigned WIDTH = 32'd21
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] last_s;

  // Terminal count; a zero limit behaves like a limit of one.
  always_comb begin
    last_s = {WIDTH{1'b0}};
    if (limit == {WIDTH{1'b0}}) begin
      last_s = {WIDTH{1'b0}};
    end else begin
      last_s = limit - WIDTH'(1);
    end
  end

  // Count register: clear on state entry, advance, saturate at terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {WIDTH{1'b0}};
    end else if (clear) begin
      count_r <= {WIDTH{1'b0}};
    end else if (count_r < last_s) begin
      count_r <= count_r + WIDTH'(1);
    end else begin
      count_r <= last_s;
    end
  end

  assign expired = (count_r == last_s);

endmodule

// File: rtl/sata_oob_ctrl.sv
// sata_oob_ctrl: host-side SATA out-of-band (OOB) link bring-up controller.
// Sequences COMRESET / COMWAKE exchanges, D10.2 and ALIGN transmission, and
// declares link-up after SYNC_COUNT consecutive non-ALIGN primitives.
// All outputs are registered copies of the state decode, so every input event
// is visible on the outputs exactly one cycle later.
// Optional build macro SATA_OOB_CTRL_STATUS_EN adds the state_code and
// retry_cnt status outputs.
module sata_oob_ctrl #(
  parameter int unsigned ALIGN_TIMEOUT = sata_oob_pkg::DEF_ALIGN_TIMEOUT,
  parameter int unsigned RETRY_TIMEOUT = sata_oob_pkg::DEF_RETRY_TIMEOUT,
  parameter int unsigned SYNC_COUNT    = sata_oob_pkg::DEF_SYNC_COUNT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cominit,
  input  logic       comwake,
  input  logic       oobfinish,
  output logic       tx_comreset,
  output logic       tx_comwake,
  input  logic       tx_oobdone,
  output logic       tx_d102,
  output logic       tx_align,
  input  logic       rx_align,
  input  logic       rx_sync,
  output logic       linkup
`ifdef SATA_OOB_CTRL_STATUS_EN
  ,
  output logic [3:0] state_code,
  output logic [7:0] retry_cnt
`endif
);

  import sata_oob_pkg::*;

  localparam int unsigned MAX_LIMIT = (ALIGN_TIMEOUT > RETRY_TIMEOUT) ? ALIGN_TIMEOUT : RETRY_TIMEOUT;
  localparam int unsigned TW        = $clog2(MAX_LIMIT + 32'd1);
  localparam int unsigned SCW       = $clog2(SYNC_COUNT + 32'd1);

  oob_state_t     state_r;
  oob_state_t     next_state_s;
  oob_tx_t        out_r;
  logic [TW-1:0]  limit_s;
  logic           timer_clear_s;
  logic           expired_s;
  logic [SCW-1:0] sync_cnt_r;
  logic           sync_good_s;
  logic           sync_done_s;

  // A usable primitive is a valid non-ALIGN one; the run completes on the
  // SYNC_COUNT-th consecutive such cycle.
  assign sync_good_s = rx_sync & ~rx_align;
  assign sync_done_s = sync_good_s && (sync_cnt_r == SCW'(SYNC_COUNT - 32'd1));

  // Select the timeout that applies to the current state; restart on entry.
  always_comb begin
    limit_s       = TW'(RETRY_TIMEOUT);
    timer_clear_s = (next_state_s != state_r);
    if ((state_r == ST_SEND_D102) || (state_r == ST_SEND_ALIGN)) begin
      limit_s = TW'(ALIGN_TIMEOUT);
    end else begin
      limit_s = TW'(RETRY_TIMEOUT);
    end
  end

  sata_oob_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear_s),
    .limit   (limit_s),
    .expired (expired_s)
  );

  // Next-state logic; device events win over a coinciding timeout.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        next_state_s = ST_COMRESET;
      end
      ST_COMRESET: begin
        if (tx_oobdone) next_state_s = ST_WAIT_COMINIT;
        else            next_state_s = ST_COMRESET;
      end
      ST_WAIT_COMINIT: begin
        if (cominit)        next_state_s = ST_COMWAKE;
        else if (expired_s) next_state_s = ST_COMRESET;
        else                next_state_s = ST_WAIT_COMINIT;
      end
      ST_COMWAKE: begin
        if (tx_oobdone) next_state_s = ST_WAIT_COMWAKE;
        else            next_state_s = ST_COMWAKE;
      end
      ST_WAIT_COMWAKE: begin
        // A fresh COMINIT means the device restarted its sequence.
        if (cominit)        next_state_s = ST_COMWAKE;
        else if (comwake)   next_state_s = ST_WAIT_OOBFIN;
        else if (expired_s) next_state_s = ST_COMRESET;
        else                next_state_s = ST_WAIT_COMWAKE;
      end
      ST_WAIT_OOBFIN: begin
        if (oobfinish)      next_state_s = ST_SEND_D102;
        else if (expired_s) next_state_s = ST_COMRESET;
        else                next_state_s = ST_WAIT_OOBFIN;
      end
      ST_SEND_D102: begin
        if (rx_align)       next_state_s = ST_SEND_ALIGN;
        else if (expired_s) next_state_s = ST_COMRESET;
        else                next_state_s = ST_SEND_D102;
      end
      ST_SEND_ALIGN: begin
        if (sync_done_s)    next_state_s = ST_LINKUP;
        else if (expired_s) next_state_s = ST_COMRESET;
        else                next_state_s = ST_SEND_ALIGN;
      end
      ST_LINKUP: begin
        if (cominit) next_state_s = ST_COMRESET;
        else         next_state_s = ST_LINKUP;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Consecutive-sync run counter; only counts while staying in SEND_ALIGN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_cnt_r <= {SCW{1'b0}};
    end else if ((state_r == ST_SEND_ALIGN) && (next_state_s == ST_SEND_ALIGN) && sync_good_s) begin
      sync_cnt_r <= sync_cnt_r + SCW'(1);
    end else begin
      sync_cnt_r <= {SCW{1'b0}};
    end
  end

  // Output register: decode of the state being entered, so outputs track state_r.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_r <= '{comreset: 1'b0, comwake: 1'b0, d102: 1'b0, align: 1'b0, linkup: 1'b0};
    end else begin
      out_r <= decode_outputs(next_state_s);
    end
  end

  assign tx_comreset = out_r.comreset;
  assign tx_comwake  = out_r.comwake;
  assign tx_d102     = out_r.d102;
  assign tx_align    = out_r.align;
  assign linkup      = out_r.linkup;

`ifdef SATA_OOB_CTRL_STATUS_EN
  logic       retry_evt_s;
  logic [7:0] retry_cnt_r;

  // A retry is any COMRESET re-entry from a waiting state, i.e. a timeout.
  always_comb begin
    retry_evt_s = 1'b0;
    if (next_state_s == ST_COMRESET) begin
      case (state_r)
        ST_WAIT_COMINIT, ST_WAIT_COMWAKE, ST_WAIT_OOBFIN,
        ST_SEND_D102, ST_SEND_ALIGN: retry_evt_s = 1'b1;
        default:                     retry_evt_s = 1'b0;
      endcase
    end else begin
      retry_evt_s = 1'b0;
    end
  end

  // Saturating retry counter, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retry_cnt_r <= 8'd0;
    end else if (retry_evt_s && (retry_cnt_r != 8'd255)) begin
      retry_cnt_r <= retry_cnt_r + 8'd1;
    end else begin
      retry_cnt_r <= retry_cnt_r;
    end
  end

  assign state_code = 4'(state_r);
  assign retry_cnt  = retry_cnt_r;
`endif

endmodule

// File: tb/tb_sata_oob_ctrl.sv
// tb_sata_oob_ctrl: directed, table-driven bench for sata_oob_ctrl.
// Short timeouts (ALIGN 60, RETRY 100) keep the timeout sequences brief.
module tb_sata_oob_ctrl;

  logic clk;
  logic reset;
  logic cominit, comwake, oobfinish, tx_oobdone, rx_align, rx_sync;
  logic tx_comreset, tx_comwake, tx_d102, tx_align, linkup;
`ifdef SATA_OOB_CTRL_STATUS_EN
  logic [3:0] state_code;
  logic [7:0] retry_cnt;
`endif

  sata_oob_ctrl #(
    .ALIGN_TIMEOUT (60),
    .RETRY_TIMEOUT (100),
    .SYNC_COUNT    (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cominit     (cominit),
    .comwake     (comwake),
    .oobfinish   (oobfinish),
    .tx_comreset (tx_comreset),
    .tx_comwake  (tx_comwake),
    .tx_oobdone  (tx_oobdone),
    .tx_d102     (tx_d102),
    .tx_align    (tx_align),
    .rx_align    (rx_align),
    .rx_sync     (rx_sync),
    .linkup      (linkup)
`ifdef SATA_OOB_CTRL_STATUS_EN
    ,
    .state_code  (state_code),
    .retry_cnt   (retry_cnt)
`endif
  );

  // Input bit order: {cominit, comwake, oobfinish, tx_oobdone, rx_align, rx_sync}
  localparam logic [5:0] I_0  = 6'b000000;
  localparam logic [5:0] I_CI = 6'b100000;
  localparam logic [5:0] I_CW = 6'b010000;
  localparam logic [5:0] I_OF = 6'b001000;
  localparam logic [5:0] I_DN = 6'b000100;
  localparam logic [5:0] I_RA = 6'b000010;
  localparam logic [5:0] I_RS = 6'b000001;
  // Output bit order: {tx_comreset, tx_comwake, tx_d102, tx_align, linkup}
  localparam logic [4:0] O_NONE = 5'b00000;
  localparam logic [4:0] O_CR   = 5'b10000;
  localparam logic [4:0] O_CW   = 5'b01000;
  localparam logic [4:0] O_D    = 5'b00100;
  localparam logic [4:0] O_AL   = 5'b00010;
  localparam logic [4:0] O_LU   = 5'b00001;

  typedef struct packed {
    logic [5:0] in;
    logic [4:0] exp;
  } vec_t;

  localparam int NVEC = 27;
  vec_t vecs [NVEC];

  int n_vec;
  int n_miss;

  logic [4:0] outs;
  assign outs = {tx_comreset, tx_comwake, tx_d102, tx_align, linkup};

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Overall time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
    $fatal(1, "time limit");
  end

  task automatic drive(input logic [5:0] v);
    {cominit, comwake, oobfinish, tx_oobdone, rx_align, rx_sync} = v;
  endtask

  // Apply inputs for one clock edge, then sample on the following falling edge.
  task automatic step(input logic [5:0] v);
    drive(v);
    @(posedge clk);
    @(negedge clk);
    drive(I_0);
  endtask

  task automatic check(input string nm, input logic [4:0] exp);
    n_vec++;
    if (outs !== exp) begin
      n_miss++;
      $display("FAIL %s: outputs got %b expected %b", nm, outs, exp);
    end
  endtask

  task automatic check_val(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Step with idle inputs until tx_comreset rises; returns cycles taken or -1.
  task automatic wait_comreset(input int bound, input logic [4:0] hold, input string nm, output int cycles);
    int hold_bad;
    cycles   = -1;
    hold_bad = 0;
    for (int k = 1; k <= bound; k++) begin
      step(I_0);
      if (tx_comreset) begin
        cycles = k;
        break;
      end else if (outs !== hold) begin
        hold_bad++;
      end
    end
    check_val({nm, "_hold_errors"}, hold_bad, 0);
  endtask

  initial begin
    int cyc;
    int bad;
    n_vec  = 0;
    n_miss = 0;

    vecs[0]  = '{in: I_0,               exp: O_CR};   // IDLE -> COMRESET
    vecs[1]  = '{in: I_CI,              exp: O_CR};   // cominit ignored in COMRESET
    vecs[2]  = '{in: I_CW,              exp: O_CR};   // comwake ignored in COMRESET
    vecs[3]  = '{in: I_DN,              exp: O_NONE}; // -> WAIT_COMINIT
    vecs[4]  = '{in: I_DN,              exp: O_NONE}; // oobdone ignored
    vecs[5]  = '{in: I_CW | I_OF,       exp: O_NONE}; // still WAIT_COMINIT
    vecs[6]  = '{in: I_CI,              exp: O_CW};   // -> COMWAKE
    vecs[7]  = '{in: I_CI,              exp: O_CW};   // cominit ignored in COMWAKE
    vecs[8]  = '{in: I_DN,              exp: O_NONE}; // -> WAIT_COMWAKE
    vecs[9]  = '{in: I_CI | I_CW,       exp: O_CW};   // cominit wins -> COMWAKE
    vecs[10] = '{in: I_DN,              exp: O_NONE}; // -> WAIT_COMWAKE
    vecs[11] = '{in: I_OF | I_RA,       exp: O_NONE}; // no transition
    vecs[12] = '{in: I_CW,              exp: O_NONE}; // -> WAIT_OOBFIN
    vecs[13] = '{in: I_0,               exp: O_NONE}; // waiting for oobfinish
    vecs[14] = '{in: I_OF,              exp: O_D};    // -> SEND_D102
    vecs[15] = '{in: I_RS,              exp: O_D};    // sync ignored in D102
    vecs[16] = '{in: I_RA,              exp: O_AL};   // -> SEND_ALIGN
    vecs[17] = '{in: I_RS,              exp: O_AL};   // run 1
    vecs[18] = '{in: I_RS | I_RA,       exp: O_AL};   // ALIGN breaks the run
    vecs[19] = '{in: I_RS,              exp: O_AL};   // run 1
    vecs[20] = '{in: I_RS,              exp: O_AL};   // run 2
    vecs[21] = '{in: I_0,               exp: O_AL};   // gap clears run
    vecs[22] = '{in: I_RS,              exp: O_AL};   // run 1
    vecs[23] = '{in: I_RS,              exp: O_AL};   // run 2
    vecs[24] = '{in: I_RS,              exp: O_LU};   // run 3 -> LINKUP
    vecs[25] = '{in: I_RA | I_RS | I_CW, exp: O_LU};  // stays up
    vecs[26] = '{in: I_CI,              exp: O_CR};   // cominit -> COMRESET

    // Reset state
    reset = 1'b1;
    drive(I_0);
    repeat (2) @(negedge clk);
    check("reset_outputs", O_NONE);
`ifdef SATA_OOB_CTRL_STATUS_EN
    check_val("reset_state_code", int'(state_code), 0);
    check_val("reset_retry_cnt", int'(retry_cnt), 0);
`endif
    reset = 1'b0;

    // COMRESET acknowledged after 20 cycles
    step(I_0);
    check("comreset_enter", O_CR);
    bad = 0;
    for (int i = 0; i < 19; i++) begin
      step(I_0);
      if (outs !== O_CR) bad++;
    end
    check_val("comreset_hold_errors", bad, 0);
    step(I_DN);
    check("comreset_fall", O_NONE);
`ifdef SATA_OOB_CTRL_STATUS_EN
    check_val("wait_cominit_code", int'(state_code), 2);
`endif

    // No cominit: retry timeout re-issues COMRESET 100 cycles after entry
    wait_comreset(150, O_NONE, "retry_timeout", cyc);
    check_val("retry_timeout_cycles", cyc, 100);
    check("retry_comreset", O_CR);
`ifdef SATA_OOB_CTRL_STATUS_EN
    check_val("retry_cnt_after_timeout", int'(retry_cnt), 1);
`endif

    // Restart from reset, then the table
    reset = 1'b1;
    @(negedge clk);
    check("reset_from_comreset", O_NONE);
`ifdef SATA_OOB_CTRL_STATUS_EN
    check_val("retry_cnt_cleared", int'(retry_cnt), 0);
`endif
    reset = 1'b0;
    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].in);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // ALIGN timeout in SEND_D102: COMRESET 60 cycles after entry
    step(I_DN);
    step(I_CI);
    step(I_DN);
    step(I_CW);
    step(I_OF);
    check("d102_enter", O_D);
    wait_comreset(100, O_D, "align_timeout", cyc);
    check_val("align_timeout_cycles", cyc, 60);
`ifdef SATA_OOB_CTRL_STATUS_EN
    check_val("retry_cnt_align_timeout", int'(retry_cnt), 1);
`endif

    // Reset asserted mid-sequence in SEND_D102
    step(I_DN);
    step(I_CI);
    step(I_DN);
    step(I_CW);
    step(I_OF);
    check("d102_again", O_D);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_outputs", O_NONE);
    @(negedge clk);
    check("reset_held_outputs", O_NONE);
`ifdef SATA_OOB_CTRL_STATUS_EN
    check_val("reset_mid_state_code", int'(state_code), 0);
`endif
    reset = 1'b0;
    step(I_0);
    check("restart_comreset", O_CR);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
